// File: rtl/wbu_regfile_if.sv
// Write-back / register-file bus.
// The EXU result handshake, the write-back stall, both operand read ports,
// the retire (commit) outputs and the retired-instruction count are grouped here.
// slave  : the write-back unit itself
// master : the EXU / IDU side that drives results and read addresses
interface wbu_regfile_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
);
    logic             ex_valid;
    logic             ex_ready;
    logic [XLEN-1:0]  ex_result;
    logic [4:0]       ex_rd;
    logic             ex_wen;
    logic             wb_stall;
    logic [4:0]       rs1_addr;
    logic [XLEN-1:0]  rs1_data;
    logic [4:0]       rs2_addr;
    logic [XLEN-1:0]  rs2_data;
    logic             wb_valid;
    logic [4:0]       wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic [CNT_W-1:0] instret;

    modport slave (
        input  ex_valid, ex_result, ex_rd, ex_wen, wb_stall, rs1_addr, rs2_addr,
        output ex_ready, rs1_data, rs2_data, wb_valid, wb_rd, wb_data, instret
    );

    modport master (
        output ex_valid, ex_result, ex_rd, ex_wen, wb_stall, rs1_addr, rs2_addr,
        input  ex_ready, rs1_data, rs2_data, wb_valid, wb_rd, wb_data, instret
    );
endinterface

// File: rtl/wbu_regfile.sv
// Write-back stage and integer register file.
// One-entry pending slot fed by the EXU over valid/ready; the slot commits to
// x1..x31 the cycle after it is accepted and retires (wb_* pulse, instret).
// Two combinational read ports serve the operand path; x0 always reads zero.
// Optional feature macro: WBU_BYPASS_EN -- when defined, the read ports forward
// the pending slot data for a matching rd, hiding the one-cycle RAW window.
// Without it, reads see only committed register contents.
module wbu_regfile #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int CNT_W = 64
) (
    input  logic          clk,
    input  logic          rst,
    wbu_regfile_if.slave  bus
);

    logic             pend_v;
    logic             pend_wen;
    logic [4:0]       pend_rd;
    logic [XLEN-1:0]  pend_data;
    logic [XLEN-1:0]  regs [1:NREG-1];
    logic [CNT_W-1:0] instret_q;

    logic             accept;
    logic             commit;

    // Handshake: the slot can take a new result when empty or draining this cycle.
    always_comb begin
        commit       = pend_v && !bus.wb_stall;
        bus.ex_ready = !pend_v || commit;
        accept       = bus.ex_valid && bus.ex_ready;
    end

    // Pending slot: a new accept overrides, otherwise a commit empties it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_v    <= 1'b0;
            pend_wen  <= 1'b0;
            pend_rd   <= '0;
            pend_data <= '0;
        end else if (accept) begin
            pend_v    <= 1'b1;
            pend_wen  <= bus.ex_wen && (bus.ex_rd != 5'd0);
            pend_rd   <= bus.ex_rd;
            pend_data <= bus.ex_result;
        end else if (commit) begin
            pend_v    <= 1'b0;
        end
    end

    // Register file write; pend_wen is never set for x0, so index 0 is never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (commit && pend_wen) begin
            regs[pend_rd] <= pend_data;
        end
    end

    // Retired-result counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            instret_q <= '0;
        end else if (commit) begin
            instret_q <= instret_q + 1'b1;
        end
    end

    // Retire outputs; rd reports 0 for results that did not write a register.
    always_comb begin
        bus.wb_valid = commit;
        bus.wb_rd    = (commit && pend_wen) ? pend_rd : 5'd0;
        bus.wb_data  = commit ? pend_data : '0;
        bus.instret  = instret_q;
    end

    // Read port 1.
    always_comb begin
        bus.rs1_data = '0;
        if (bus.rs1_addr != 5'd0) begin
            bus.rs1_data = regs[bus.rs1_addr];
`ifdef WBU_BYPASS_EN
            if (pend_v && pend_wen && (bus.rs1_addr == pend_rd)) begin
                bus.rs1_data = pend_data;
            end
`endif
        end
    end

    // Read port 2.
    always_comb begin
        bus.rs2_data = '0;
        if (bus.rs2_addr != 5'd0) begin
            bus.rs2_data = regs[bus.rs2_addr];
`ifdef WBU_BYPASS_EN
            if (pend_v && pend_wen && (bus.rs2_addr == pend_rd)) begin
                bus.rs2_data = pend_data;
            end
`endif
        end
    end

endmodule
